// File: rtl/ahb_apb_master_arb_pkg.sv
// Shared encodings for the two-master AHB-lite arbiter in front of the APB bridge.
// Transfer types, responses, arbiter owner and error-response state codes.
package ahb_apb_master_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam logic [1:0] ERR_IDLE = 2'b00;
  localparam logic [1:0] ERR_1    = 2'b01;
  localparam logic [1:0] ERR_2    = 2'b10;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Local default slave: two-cycle ERROR response for out-of-window transfers and
// the shared Hready/Hresp mux between the error responder and the bridge.
module ahb_default_slave
  import ahb_apb_master_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dsel_err,
  input  logic       dsel_bridge,
  input  logic       miss_addr,
  input  logic       bridge_ready,
  input  logic [1:0] bridge_resp,
  output logic       ready,
  output logic [1:0] resp,
  output logic       err_busy
);

  logic [1:0] err_state_r;
  logic [1:0] err_next_s;
  logic       accept_miss_s;

  assign accept_miss_s = ready & miss_addr;
  assign err_busy      = (err_state_r == ERR_1);

  // Shared ready/response seen by both masters
  always_comb begin
    ready = 1'b1;
    resp  = HRESP_OKAY;
    if (dsel_err) begin
      case (err_state_r)
        ERR_1: begin
          ready = 1'b0;
          resp  = HRESP_ERROR;
        end
        ERR_2: begin
          ready = 1'b1;
          resp  = HRESP_ERROR;
        end
        default: begin
          ready = 1'b1;
          resp  = HRESP_OKAY;
        end
      endcase
    end else if (dsel_bridge) begin
      ready = bridge_ready;
      resp  = bridge_resp;
    end else begin
      ready = 1'b1;
      resp  = HRESP_OKAY;
    end
  end

  // Error FSM next state; a miss accepted during ERR_2 re-enters ERR_1 directly
  always_comb begin
    err_next_s = ERR_IDLE;
    case (err_state_r)
      ERR_IDLE: err_next_s = accept_miss_s ? ERR_1 : ERR_IDLE;
      ERR_1:    err_next_s = ERR_2;
      ERR_2:    err_next_s = accept_miss_s ? ERR_1 : ERR_IDLE;
      default:  err_next_s = ERR_IDLE;
    endcase
  end

  // Error FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_state_r <= ERR_IDLE;
    end else begin
      err_state_r <= err_next_s;
    end
  end

endmodule

// File: rtl/ahb_apb_master_arb.sv
// Two-master AHB-lite round-robin arbiter and bridge-window decoder.
// Optional bus locking is compiled in with the ARB_LOCK_EN macro.
module ahb_apb_master_arb
  import ahb_apb_master_arb_pkg::*;
#(
  parameter logic [31:0] BRIDGE_BASE = 32'h0000_0000,
  parameter logic [31:0] BRIDGE_MASK = 32'hFFFF_0000
) (
  input  logic        Hclk,
  input  logic        Hrstn,
  input  logic        Hbusreq_m0,
  input  logic        Hbusreq_m1,
  input  logic [1:0]  Htrans_m0,
  input  logic [1:0]  Htrans_m1,
  input  logic [31:0] Haddr_m0,
  input  logic [31:0] Haddr_m1,
  input  logic        Hwrite_m0,
  input  logic        Hwrite_m1,
  input  logic [31:0] Hwdata_m0,
  input  logic [31:0] Hwdata_m1,
`ifdef ARB_LOCK_EN
  input  logic        Hlock_m0,
  input  logic        Hlock_m1,
`endif
  output logic        Hgrant_m0,
  output logic        Hgrant_m1,
  output logic        Hmaster,
  output logic [1:0]  Htrans,
  output logic [31:0] Haddr,
  output logic        Hwrite,
  output logic [31:0] Hwdata,
  output logic        Hsel_APB,
  input  logic        Hready_out,
  input  logic [1:0]  Hresp_in,
  output logic        Hready,
  output logic [1:0]  Hresp
);

  logic       owner_r;
  logic       ptr_r;
  logic       downer_r;
  logic       dsel_bridge_r;
  logic       dsel_err_r;
  logic [1:0] htrans_s;
  logic       own_req_s;
  logic       other_req_s;
  logic       own_free_s;
  logic       hit_s;
  logic       miss_s;
  logic       handover_s;
  logic       lock_block_s;
  logic       ready_s;
  logic       err_busy_s;

  // Address-phase mux by current owner
  always_comb begin
    htrans_s    = Htrans_m0;
    Haddr       = Haddr_m0;
    Hwrite      = Hwrite_m0;
    own_req_s   = Hbusreq_m0;
    other_req_s = Hbusreq_m1;
    if (owner_r == OWN_M1) begin
      htrans_s    = Htrans_m1;
      Haddr       = Haddr_m1;
      Hwrite      = Hwrite_m1;
      own_req_s   = Hbusreq_m1;
      other_req_s = Hbusreq_m0;
    end else begin
      htrans_s    = Htrans_m0;
      Haddr       = Haddr_m0;
      Hwrite      = Hwrite_m0;
      own_req_s   = Hbusreq_m0;
      other_req_s = Hbusreq_m1;
    end
  end

  // Write data follows whoever owned the previous accepted address phase
  always_comb begin
    Hwdata = Hwdata_m0;
    if (downer_r == OWN_M1) begin
      Hwdata = Hwdata_m1;
    end else begin
      Hwdata = Hwdata_m0;
    end
  end

  assign Htrans    = htrans_s;
  assign Hmaster   = owner_r;
  assign Hgrant_m0 = (owner_r == OWN_M0);
  assign Hgrant_m1 = (owner_r == OWN_M1);
  assign hit_s     = addr_hit(Haddr, BRIDGE_BASE, BRIDGE_MASK);
  assign miss_s    = htrans_s[1] & ~hit_s;
  assign Hsel_APB  = htrans_s[1] & hit_s & ~err_busy_s;
  assign Hready    = ready_s;

  // A burst in progress (SEQ/BUSY) is never broken; a requesting owner keeps the bus until IDLE
  assign own_free_s = (htrans_s == HTRANS_IDLE) ||
                      (!own_req_s && (htrans_s != HTRANS_SEQ) && (htrans_s != HTRANS_BUSY));
  assign handover_s = ready_s & own_free_s & other_req_s & ~lock_block_s;

`ifdef ARB_LOCK_EN
  logic lock_r;
  logic own_lock_s;

  assign own_lock_s   = (owner_r == OWN_M1) ? Hlock_m1 : Hlock_m0;
  assign lock_block_s = lock_r | (own_lock_s & (htrans_s == HTRANS_NONSEQ));

  // Lock is captured with a locked NONSEQ and released by an unlocked IDLE
  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) begin
      lock_r <= 1'b0;
    end else if (ready_s) begin
      if (handover_s) begin
        lock_r <= 1'b0;
      end else if (own_lock_s && (htrans_s == HTRANS_NONSEQ)) begin
        lock_r <= 1'b1;
      end else if (!own_lock_s && (htrans_s == HTRANS_IDLE)) begin
        lock_r <= 1'b0;
      end
    end
  end
`else
  assign lock_block_s = 1'b0;
`endif

  // Owner and round-robin pointer; both frozen while Hready is low
  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) begin
      owner_r <= OWN_M0;
      ptr_r   <= OWN_M1;
    end else if (handover_s) begin
      owner_r <= ptr_r;
      ptr_r   <= owner_r;
    end
  end

  // Data-phase tracking registers
  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) begin
      downer_r      <= OWN_M0;
      dsel_bridge_r <= 1'b0;
      dsel_err_r    <= 1'b0;
    end else if (ready_s) begin
      downer_r      <= owner_r;
      dsel_bridge_r <= htrans_s[1] & hit_s;
      dsel_err_r    <= miss_s;
    end
  end

  ahb_default_slave u_default_slave (
    .clk          (Hclk),
    .rst_n        (Hrstn),
    .dsel_err     (dsel_err_r),
    .dsel_bridge  (dsel_bridge_r),
    .miss_addr    (miss_s),
    .bridge_ready (Hready_out),
    .bridge_resp  (Hresp_in),
    .ready        (ready_s),
    .resp         (Hresp),
    .err_busy     (err_busy_s)
  );

endmodule

// File: doc/ahb_apb_master_arb.md
Name: ahb_apb_master_arb

Overview:
- Two-master AHB-lite arbiter and address decoder in front of the single AHB-to-APB bridge slave port.
- Grants the bus round-robin and never breaks a burst.
- Muxes address/control in the address phase and write data in the data phase.
- Generates Hsel_APB for the bridge window; out-of-window transfers get a local two-cycle ERROR response.

Parameters:
- BRIDGE_BASE, 32'h0000_0000, base address of the bridge window
- BRIDGE_MASK, 32'hFFFF_0000, compare mask; hit = (Haddr & MASK) == BASE

Ports:
- Hclk  in  1  bus clock, rising edge
- Hrstn  in  1  asynchronous active-low reset
- Hbusreq_m0, Hbusreq_m1  in  1  bus request per master
- Htrans_m0, Htrans_m1  in  2  transfer type per master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- Haddr_m0, Haddr_m1  in  32  address per master
- Hwrite_m0, Hwrite_m1  in  1  direction per master
- Hwdata_m0, Hwdata_m1  in  32  write data per master
- Hgrant_m0, Hgrant_m1  out  1  address-phase grant (one-hot)
- Hmaster  out  1  current address-phase owner
- Htrans, Haddr, Hwrite  out  2/32/1  muxed to bridge
- Hwdata  out  32  muxed by data-phase owner
- Hsel_APB  out  1  bridge select
- Hready_out  in  1  bridge ready
- Hresp_in  in  2  bridge response
- Hready  out  1  shared ready to masters
- Hresp  out  2  shared response to masters

Behaviour:
- Reset (async on Hrstn=0): owner=M0 parked, Hgrant_m0=1, Hgrant_m1=0, Hmaster=0, data-phase owner=0, dsel_bridge=0, dsel_err=0, error FSM ERR_IDLE, Hready=1, Hresp=00, round-robin pointer favours M1.
- Arbiter states OWN_M0 and OWN_M1; grant outputs decode the state combinationally.
- Handover is registered. At a rising edge it requires all of:
  - Hready=1;
  - owner's Htrans==IDLE, or owner's Hbusreq==0 with owner not in SEQ/BUSY;
  - the other master's Hbusreq==1.
- The new owner drives its first address phase in the cycle after the edge.
- Simultaneous requests at a handover point go to the master not last granted. The pointer flips on every handover.
- No requests: grant parks on the last owner. Its Htrans (normally IDLE) is forwarded.
- Htrans/Haddr/Hwrite are combinational muxes by Hmaster. Hsel_APB = Htrans[1] & hit & ~err_busy.
- On each edge with Hready=1, register the data phase:
  - data-phase owner <= Hmaster;
  - dsel_bridge <= Htrans[1] & hit;
  - dsel_err <= Htrans[1] & ~hit.
- Hwdata is muxed by the data-phase owner.
- Hready/Hresp:
  - dsel_err: driven by the error FSM.
  - dsel_bridge: Hready=Hready_out, Hresp=Hresp_in.
  - Otherwise: Hready=1, Hresp=00.
- Error FSM:
  - ERR_IDLE -> ERR_1 when dsel_err is registered 1.
  - ERR_1: Hready=0, Hresp=01.
  - ERR_2: Hready=1, Hresp=01; then -> ERR_IDLE, or straight back to ERR_1 if another miss was accepted.
  - err_busy=1 in ERR_1.
- Hready=0 freezes owner, pointer and data-phase registers. Handover is impossible mid-wait.
- Reset mid-burst aborts immediately to the reset state. The bridge is expected to reset on the same Hrstn.
- Latency: zero-cycle combinational address path; one-cycle registered grant change.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - adds inputs Hlock_m0, Hlock_m1 (1 bit each);
  - a lock registered with the owner's NONSEQ blocks handover until a Hready=1 edge where the owner's Hlock=0 and its Htrans==IDLE.
- Undefined: the ports are absent and handover ignores locking.

Decomposition:
- Shared package holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01;
  - arbiter state encodings OWN_M0/OWN_M1;
  - error FSM encodings ERR_IDLE/ERR_1/ERR_2.
- One natural sub-module: ahb_default_slave (error FSM, Hready/Hresp generation).

Test Plan:
- Reset, then only M0 requests; M0 NONSEQ read at 32'h20 -> Hgrant_m0=1, Hsel_APB=1 in the same cycle; bridge Prdata 16 returns on Hrdata with Hresp=00.
- Both request at an IDLE handover point with last owner M0 -> Hgrant_m1=1 after one edge; the next simultaneous point grants M0.
- M0 four-beat SEQ write (addr 0,100,1000,1100; data F,F0,F00,F000) while M1 requests -> no handover until M0 Htrans=IDLE; Hwdata follows the data-phase owner beat-accurately.
- Access to 32'h0001_0000 -> Hsel_APB=0; Hready 0 then 1 with Hresp=01 for both cycles; the next bridge access is OKAY.
- Hrstn pulled low mid-burst with Hready_out=0 -> all outputs at reset values asynchronously; M0 parked.
- ARB_LOCK_EN: M0 locked over two separate NONSEQ transfers with an IDLE between them while M1 requests -> grant stays on M0 until Hlock_m0=0.
